// File: rtl/onehot_seq_pkg.sv
// rtl/onehot_seq_pkg.sv - shared constants and state encoding for the one-hot channel sequencer
package onehot_seq_pkg;

    localparam int DEF_SIZE    = 3;
    localparam int DEF_DWELL_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/onehot_dec.sv
// rtl/onehot_dec.sv - combinational binary-to-one-hot decoder
module onehot_dec
    import onehot_seq_pkg::*;
#(
    parameter int SIZE = DEF_SIZE
) (
    input  logic [SIZE-1:0]      i_idx,
    output logic [(1<<SIZE)-1:0] o_onehot
);

    always_comb begin
        o_onehot        = '0;
        o_onehot[i_idx] = 1'b1;
    end

endmodule

// File: rtl/onehot_seq.sv
// rtl/onehot_seq.sv - one-hot channel select sequencer with dwell hold, break-before-make gap and sweep
module onehot_seq
    import onehot_seq_pkg::*;
#(
    parameter int SIZE    = DEF_SIZE,
    parameter int DWELL_W = DEF_DWELL_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SIZE-1:0]      in_idx,
    input  logic [DWELL_W-1:0]   in_dwell,
    input  logic                 in_sweep,
    input  logic                 abort,
    output logic [(1<<SIZE)-1:0] sel,
    output logic                 busy,
    output logic                 done
);

    localparam logic [SIZE-1:0] IDX_MAX = '1;

    state_t                r_state;
    logic [SIZE-1:0]       r_idx;
    logic                  r_sweep;
    logic [DWELL_W-1:0]    r_dwell;
    logic [DWELL_W-1:0]    r_cnt;
    logic [(1<<SIZE)-1:0]  r_sel;
    logic                  r_busy;
    logic                  r_done;

    logic [DWELL_W-1:0]    w_eff_dwell;
    logic                  w_more;
    logic [SIZE-1:0]       w_dec_idx;
    logic [(1<<SIZE)-1:0]  w_onehot;

    assign w_eff_dwell = (in_dwell == '0) ? DWELL_W'(1) : in_dwell;
    assign w_more      = r_sweep && (r_idx != IDX_MAX);
    // The decoder serves both the accept path and the sweep step out of GAP.
    assign w_dec_idx   = (r_state == ST_GAP) ? r_idx + SIZE'(1) : in_idx;
    assign in_ready    = (r_state == ST_IDLE) && !abort;

    onehot_dec #(.SIZE(SIZE)) u_dec (
        .i_idx    (w_dec_idx),
        .o_onehot (w_onehot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_sweep <= 1'b0;
            r_dwell <= '0;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (in_valid && !abort) begin
                        r_state <= ST_HOLD;
                        r_idx   <= in_idx;
                        r_sweep <= in_sweep;
                        r_dwell <= w_eff_dwell;
                        r_cnt   <= w_eff_dwell;
                        r_sel   <= w_onehot;
                        r_busy  <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_sel   <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt <= DWELL_W'(1)) begin
                        // done is raised entering the final gap so it lines up with that cycle
                        r_state <= ST_GAP;
                        r_cnt   <= '0;
                        r_sel   <= '0;
                        r_done  <= !w_more;
                    end else begin
                        r_cnt <= r_cnt - DWELL_W'(1);
                    end
                end
                ST_GAP: begin
                    if (abort || !w_more) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_sel   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_HOLD;
                        r_idx   <= r_idx + SIZE'(1);
                        r_cnt   <= r_dwell;
                        r_sel   <= w_onehot;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_sel   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sel  = r_sel;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_onehot_seq.sv
// tb/tb_onehot_seq.sv - scoreboard testbench for onehot_seq
module tb_onehot_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_idx;
    logic [7:0] in_dwell;
    logic       in_sweep;
    logic       abort;
    logic [7:0] sel;
    logic       busy;
    logic       done;

    typedef struct packed {
        logic [7:0] sel;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    int   total    = 0;
    int   bad      = 0;
    int   done_cnt = 0;

    onehot_seq #(.SIZE(3), .DWELL_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_idx   (in_idx),
        .in_dwell (in_dwell),
        .in_sweep (in_sweep),
        .abort    (abort),
        .sel      (sel),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    // Expected busy-cycle trace: per channel, dwell cycles of its bit, then one gap.
    task automatic push_seq(input int idx, input int dwell, input bit sweep, output int n);
        int   eff;
        bit   last;
        exp_t e;
        eff = (dwell == 0) ? 1 : dwell;
        n   = 0;
        for (int ch = idx; ch < 8; ch++) begin
            for (int k = 0; k < eff; k++) begin
                e.sel = 8'(1 << ch); e.done = 1'b0;
                exp_q.push_back(e); n++;
            end
            last   = !(sweep && ch != 7);
            e.sel  = 8'h00; e.done = last;
            exp_q.push_back(e); n++;
            if (last) break;
        end
    endtask

    task automatic run_req(input logic [2:0] idx, input int dwell, input bit sweep, input int poke);
        int n;
        int cyc;
        push_seq(idx, dwell, sweep, n);
        in_idx = idx; in_dwell = 8'(dwell); in_sweep = sweep; in_valid = 1'b1;
        #1 chk("accept_ready", in_ready, 1);
        @(posedge clk); #1;
        if (poke > 0) begin
            in_idx = ~idx; in_dwell = 8'd1; in_sweep = 1'b0;
        end else begin
            in_valid = 1'b0;
        end
        cyc = 0;
        for (int g = 0; g < 300; g++) begin
            @(negedge clk);
            if (!busy) break;
            cyc++;
            if (cyc == poke) in_valid = 1'b0;
        end
        chk("busy_cycles", cyc, n);
        chk("ready_after", in_ready, 1);
        chk("sb_drained", exp_q.size(), 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && busy) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb_extra: got sel=%0h done=%0b want no output", sel, done);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_sel", sel, e.sel);
                    chk("sb_done", done, e.done);
                end
            end
            if (done) done_cnt++;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int   d0;
        exp_t e;
        rst_n = 1'b0; in_valid = 1'b0; in_idx = '0; in_dwell = '0; in_sweep = 1'b0; abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sel", sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1 chk("rst_ready", in_ready, 1);
        @(negedge clk);

        run_req(3'd5, 3, 1'b0, 0);
        run_req(3'd6, 2, 1'b1, 0);
        run_req(3'd0, 0, 1'b0, 0);
        run_req(3'd3, 1, 1'b1, 0);
        run_req(3'd7, 4, 1'b1, 0);
        run_req(3'd1, 4, 1'b0, 3);

        e.sel = 8'h04; e.done = 1'b0;
        exp_q.push_back(e); exp_q.push_back(e);
        in_idx = 3'd2; in_dwell = 8'd5; in_sweep = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        d0 = done_cnt;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_sel", sel, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", in_ready, 1);
        chk("abort_sb", exp_q.size(), 0);
        repeat (8) @(negedge clk);
        #1 chk("abort_no_done", done_cnt, d0);

        in_idx = 3'd4; in_dwell = 8'd2; in_valid = 1'b1; abort = 1'b1;
        #1 chk("abort_idle_ready", in_ready, 0);
        @(posedge clk); #1 in_valid = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("abort_idle_busy", busy, 0);
        chk("abort_idle_sel", sel, 0);

        e.sel = 8'h10; e.done = 1'b0;
        exp_q.push_back(e); exp_q.push_back(e); exp_q.push_back(e);
        e.sel = 8'h00; exp_q.push_back(e);
        e.sel = 8'h20; exp_q.push_back(e);
        in_idx = 3'd4; in_dwell = 8'd3; in_sweep = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_sel", sel, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_sb", exp_q.size(), 0);
        d0 = done_cnt;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1 chk("midrst_ready", in_ready, 1);
        repeat (3) @(negedge clk);
        #1 chk("midrst_no_done", done_cnt, d0);
        @(negedge clk);
        run_req(3'd2, 2, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
